sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
- Single-clock, parametrised FIFO. It is the next-generation buffer for blocks that share one clock domain, so it needs no pointer synchronisers.
- Adds the following over the dual-clock FIFO:
  - fill-level output
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow error flags
  - synchronous flush
  - selectable first-word-fall-through (FWFT) read mode
- Sits between producer and consumer pipelines inside one clock domain.

Parameters:
- DATA_WIDTH, 16: width of wdata and rdata.
- ADDR_SIZE, 12: address bits; DEPTH = 2**ADDR_SIZE entries.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AF_THRESH, 2**ADDR_SIZE-2: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of pointers and flags; storage contents are not cleared.
- winc  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- wfull  out  1  FIFO full.
- rinc  in  1  read request (standard mode) or pop (FWFT mode).
- rdata  out  DATA_WIDTH  read data.
- rempty  out  1  FIFO empty (FWFT mode: no valid word on rdata).
- count  out  ADDR_SIZE+1  number of stored words, 0..DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- overflow  out  1  sticky; a write was attempted while wfull.
- underflow  out  1  sticky; a read was attempted while rempty.

Behaviour:
- Reset (rst_n low at an edge) sets:
  - wptr, rptr and count to 0
  - rempty=1, wfull=0, almost_empty=1, almost_full=0
  - overflow=0, underflow=0, rdata=0
  - FWFT output-valid register to 0.
- Pointers are ADDR_SIZE+1-bit binary; the MSB is the wrap bit.
  - empty when wptr==rptr
  - full when the MSBs differ and the lower bits are equal
  - count = wptr - rptr, modulo 2**(ADDR_SIZE+1).
- Write accepted iff winc && !wfull. On acceptance, mem[wptr[ADDR_SIZE-1:0]] <= wdata and wptr increments. Increment wraps naturally at 2**(ADDR_SIZE+1).
- Read accepted iff rinc && !rempty. rptr increments.
- All status outputs are registered and reflect pointer state after the edge.
  - A write on edge T clears rempty after T (standard mode).
  - A write that fills the FIFO sets wfull after T.
- Standard mode (FWFT=0):
  - A read accepted at edge T presents the word on rdata after T (latency 1).
  - rdata holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - A one-entry output register is prefetched from memory.
  - The first write into an empty FIFO at edge T shows the word on rdata and drops rempty after edge T+1.
  - rinc consumes the displayed word. The next word appears on the same edge if one is available, otherwise rempty rises.
  - count includes the word held in the output register.
- Simultaneous read and write:
  - When neither full nor empty, both proceed and count is unchanged.
  - When full, the read proceeds, the write is rejected, and overflow is set.
  - When empty in standard mode, the write proceeds, the read is rejected, and underflow is set.
- overflow and underflow are sticky. Only rst_n or flush clears them.
- flush on edge T:
  - wptr=rptr=0, count=0, rempty=1, wfull=0, FWFT valid=0
  - error flags cleared.
  - winc and rinc are ignored on that edge.
  - rdata holds its value.
- Reset or flush in the middle of a burst discards all stored words. The first write after deassertion lands at address 0.
- Threshold legality: 0 <= AE_THRESH < AF_THRESH <= DEPTH. Violations are caught by an elaboration-time check that stops simulation.

Optional Feature:
- Macro SYNC_FIFO_WATERMARK_EN.
- When defined:
  - adds output port max_count (ADDR_SIZE+1 bits).
  - max_count is a registered high-water mark: max_count <= max(max_count, count) every cycle.
  - cleared by rst_n or flush.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include sync_fifo_pkg holds:
  - pointer-width function clog2
  - status-bit index constants for the debug status bus (EMPTY, FULL, AE, AF, OVF, UNF)
  - the threshold-check macro.
- One sub-module, sync_fifo_mem:
  - simple dual-port RAM, one clock, write enable, registered read with read enable
  - infers block RAM
  - FWFT prefetch logic stays in the top level.

Test Plan:
- Use ADDR_SIZE=4, DEPTH=16, DATA_WIDTH=16, AF_THRESH=14, AE_THRESH=2 unless noted.
1. Fill and drain: write 0x0001..0x0010 → wfull=1 after the 16th write and count=16. Read 16 words → rdata sequence 0x0001..0x0010, then rempty=1.
2. Thresholds: write 3 words → almost_empty falls after the 3rd. Write up to 14 → almost_full rises after the 14th. Read 1 → almost_full falls.
3. Errors: write while full → overflow=1, count stays 16, data unchanged. Drain, then rinc while empty → underflow=1. flush → both flags 0.
4. Wrap and simultaneous: run 40 cycles of winc=rinc=1 at count=8 → count stays 8, data in order across pointer wrap.
5. FWFT=1: write 0xA5A5 into empty FIFO at edge T → rdata=0xA5A5 and rempty=0 after T+1. rinc → rempty=1 next edge.
6. Reset mid-burst: 5 words stored, rst_n low 1 cycle → count=0, rempty=1. Next write of 0x1234, then read → 0x1234.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock programmable FIFO: pointer-width helper,
// debug status-bus bit indices and the elaboration-time threshold check macro.
`ifndef SYNC_FIFO_PKG_SV
`define SYNC_FIFO_PKG_SV

// Stops elaboration when the almost-empty/almost-full thresholds cannot be met.
`define SYNC_FIFO_CHECK_THRESH(AE, AF, DEPTH) \
    if (!(((AE) >= 0) && ((AE) < (AF)) && ((AF) <= (DEPTH)))) begin : g_thresh_illegal \
        $fatal(1, "sync_fifo: require 0 <= AE_THRESH < AF_THRESH <= DEPTH"); \
    end

package sync_fifo_pkg;

    localparam int STS_EMPTY = 0;
    localparam int STS_FULL  = 1;
    localparam int STS_AE    = 2;
    localparam int STS_AF    = 3;
    localparam int STS_OVF   = 4;
    localparam int STS_UNF   = 5;
    localparam int STS_W     = 6;

    typedef logic [STS_W-1:0] status_t;

    // An empty FIFO is always at or below any legal almost-empty threshold.
    localparam status_t STS_RESET = status_t'((1 << STS_EMPTY) | (1 << STS_AE));

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM for the FIFO: one clock, write enable, registered read
// port with read enable; the read register resets to zero so rdata starts clean.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_SIZE  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_SIZE-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= ram[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with fill level, programmable almost flags, sticky error flags,
// flush and optional FWFT read; define SYNC_FIFO_WATERMARK_EN to add max_count.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_SIZE  = 12,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (2 ** ADDR_SIZE) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic [ADDR_SIZE:0]    count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    output logic [ADDR_SIZE:0]    max_count
`endif
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam int PTR_W = clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_CNT   = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_CNT   = PTR_W'(AE_THRESH);

    `SYNC_FIFO_CHECK_THRESH(AE_THRESH, AF_THRESH, DEPTH)

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] count_q;
    logic [PTR_W-1:0] count_n;
    logic             ov;
    logic             ov_n;
    status_t          status_q;
    status_t          status_n;
    logic             wr_acc;
    logic             pop;
    logic             fetch;

    // In FWFT mode rptr tracks words moved into the output register, so the
    // word on rdata is counted separately through ov; full/empty therefore come
    // from the tracked fill level rather than a direct pointer compare.
    always_comb begin
        wr_acc = winc && !status_q[STS_FULL] && !flush;
        pop    = 1'b0;
        fetch  = 1'b0;
        if (FWFT != 0) begin
            pop   = rinc && ov && !flush;
            fetch = (wptr != rptr) && (!ov || pop) && !flush;
        end else begin
            pop   = rinc && !status_q[STS_EMPTY] && !flush;
            fetch = pop;
        end

        count_n = count_q + PTR_W'(wr_acc) - PTR_W'(pop);

        ov_n = ov;
        if (FWFT != 0) begin
            if (fetch) begin
                ov_n = 1'b1;
            end else if (pop) begin
                ov_n = 1'b0;
            end
        end

        status_n            = '0;
        status_n[STS_EMPTY] = (FWFT != 0) ? !ov_n : (count_n == '0);
        status_n[STS_FULL]  = (count_n == FULL_CNT);
        status_n[STS_AE]    = (count_n <= AE_CNT);
        status_n[STS_AF]    = (count_n >= AF_CNT);
        status_n[STS_OVF]   = status_q[STS_OVF] || (winc && status_q[STS_FULL]);
        status_n[STS_UNF]   = status_q[STS_UNF] || (rinc && status_q[STS_EMPTY]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count_q  <= '0;
            ov       <= 1'b0;
            status_q <= STS_RESET;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (fetch) begin
                rptr <= rptr + PTR_W'(1);
            end
            count_q  <= count_n;
            ov       <= ov_n;
            status_q <= status_n;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_SIZE  (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc && rst_n),
        .waddr (wptr[ADDR_SIZE-1:0]),
        .wdata (wdata),
        .re    (fetch),
        .raddr (rptr[ADDR_SIZE-1:0]),
        .rdata (rdata)
    );

    assign count        = count_q;
    assign rempty       = status_q[STS_EMPTY];
    assign wfull        = status_q[STS_FULL];
    assign almost_empty = status_q[STS_AE];
    assign almost_full  = status_q[STS_AF];
    assign overflow     = status_q[STS_OVF];
    assign underflow    = status_q[STS_UNF];

`ifdef SYNC_FIFO_WATERMARK_EN
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            max_count <= '0;
        end else if (count_q > max_count) begin
            max_count <= count_q;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: one standard-mode and one FWFT instance,
// both DEPTH=16, AF_THRESH=14, AE_THRESH=2.
module tb_sync_fifo_prog;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        s_flush, s_winc, s_rinc;
    logic [15:0] s_wdata, s_rdata;
    logic        s_wfull, s_rempty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0]  s_count;

    logic        f_flush, f_winc, f_rinc;
    logic [15:0] f_wdata, f_rdata;
    logic        f_wfull, f_rempty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0]  f_count;

`ifdef SYNC_FIFO_WATERMARK_EN
    logic [4:0]  s_max, f_max;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(16), .ADDR_SIZE(4), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .winc(s_winc), .wdata(s_wdata),
        .wfull(s_wfull), .rinc(s_rinc), .rdata(s_rdata), .rempty(s_rempty), .count(s_count),
        .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf)
`ifdef SYNC_FIFO_WATERMARK_EN
        , .max_count(s_max)
`endif
    );

    sync_fifo_prog #(.DATA_WIDTH(16), .ADDR_SIZE(4), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .winc(f_winc), .wdata(f_wdata),
        .wfull(f_wfull), .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty), .count(f_count),
        .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
`ifdef SYNC_FIFO_WATERMARK_EN
        , .max_count(f_max)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic s_write(input int val);
        s_winc = 1'b1; s_wdata = 16'(val);
        tick();
        s_winc = 1'b0;
    endtask

    task automatic s_read();
        s_rinc = 1'b1;
        tick();
        s_rinc = 1'b0;
    endtask

    task automatic f_write(input int val);
        f_winc = 1'b1; f_wdata = 16'(val);
        tick();
        f_winc = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        s_flush = 1'b0; s_winc = 1'b0; s_rinc = 1'b0; s_wdata = '0;
        f_flush = 1'b0; f_winc = 1'b0; f_rinc = 1'b0; f_wdata = '0;
        tick(); tick();
        rst_n = 1'b1;

        // reset state
        chk("rst_rempty", int'(s_rempty), 1);
        chk("rst_wfull",  int'(s_wfull),  0);
        chk("rst_count",  int'(s_count),  0);
        chk("rst_ae",     int'(s_ae),     1);
        chk("rst_af",     int'(s_af),     0);
        chk("rst_ovf",    int'(s_ovf),    0);
        chk("rst_unf",    int'(s_unf),    0);
        chk("rst_rdata",  int'(s_rdata),  0);
        chk("rst_f_rempty", int'(f_rempty), 1);

        // fill 0x0001..0x0010 with threshold tracking
        for (int k = 1; k <= 16; k++) begin
            s_write(k);
            chk("fill_count", int'(s_count), k);
            chk("fill_rempty", int'(s_rempty), 0);
            chk("fill_ae", int'(s_ae), (k <= 2) ? 1 : 0);
            chk("fill_af", int'(s_af), (k >= 14) ? 1 : 0);
            chk("fill_wfull", int'(s_wfull), (k == 16) ? 1 : 0);
        end

        // write while full
        s_write(16'hDEAD);
        chk("ovf_flag",  int'(s_ovf),   1);
        chk("ovf_count", int'(s_count), 16);
        chk("ovf_wfull", int'(s_wfull), 1);

        // drain: data unchanged by the rejected write
        for (int k = 1; k <= 16; k++) begin
            s_read();
            chk("drain_rdata", int'(s_rdata), k);
            chk("drain_count", int'(s_count), 16 - k);
            chk("drain_af", int'(s_af), ((16 - k) >= 14) ? 1 : 0);
        end
        chk("drain_rempty", int'(s_rempty), 1);
        chk("drain_wfull",  int'(s_wfull),  0);
        tick();
        chk("rdata_hold", int'(s_rdata), 16'h0010);

        // read while empty
        s_read();
        chk("unf_flag",  int'(s_unf),   1);
        chk("unf_count", int'(s_count), 0);
        chk("unf_rdata", int'(s_rdata), 16'h0010);
        chk("ovf_sticky", int'(s_ovf),  1);

        // flush clears flags, ignores winc, holds rdata
        s_flush = 1'b1; s_winc = 1'b1; s_wdata = 16'h0055;
        tick();
        s_flush = 1'b0; s_winc = 1'b0;
        chk("flush_ovf",    int'(s_ovf),    0);
        chk("flush_unf",    int'(s_unf),    0);
        chk("flush_count",  int'(s_count),  0);
        chk("flush_rempty", int'(s_rempty), 1);
        chk("flush_rdata",  int'(s_rdata),  16'h0010);
        s_write(16'h0077);
        s_read();
        chk("post_flush_rdata", int'(s_rdata), 16'h0077);

        // simultaneous read/write while empty: write wins, underflow set
        s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 16'h0099;
        tick();
        s_winc = 1'b0; s_rinc = 1'b0;
        chk("sim_empty_unf",   int'(s_unf),    1);
        chk("sim_empty_count", int'(s_count),  1);
        s_read();
        chk("sim_empty_rdata", int'(s_rdata), 16'h0099);

        // steady state at count 8 across pointer wrap
        for (int k = 0; k < 8; k++) s_write(16'h0100 + k);
        chk("wrap_pre_count", int'(s_count), 8);
        for (int k = 0; k < 40; k++) begin
            s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 16'(16'h0108 + k);
            tick();
            chk("wrap_rdata", int'(s_rdata), 16'h0100 + k);
            chk("wrap_count", int'(s_count), 8);
        end
        s_winc = 1'b0; s_rinc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_read();
            chk("wrap_tail_rdata", int'(s_rdata), 16'h0128 + k);
        end
        chk("wrap_rempty", int'(s_rempty), 1);

        // simultaneous read/write while full: read wins, overflow set
        for (int k = 0; k < 16; k++) s_write(16'h0200 + k);
        s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 16'hBEEF;
        tick();
        s_winc = 1'b0; s_rinc = 1'b0;
        chk("sim_full_count", int'(s_count), 15);
        chk("sim_full_ovf",   int'(s_ovf),   1);
        chk("sim_full_rdata", int'(s_rdata), 16'h0200);

        // reset mid-burst
        s_flush = 1'b1; tick(); s_flush = 1'b0;
        for (int k = 0; k < 5; k++) s_write(16'h0300 + k);
        chk("burst_count", int'(s_count), 5);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mid_rst_count",  int'(s_count),  0);
        chk("mid_rst_rempty", int'(s_rempty), 1);
        chk("mid_rst_ovf",    int'(s_ovf),    0);
        s_write(16'h1234);
        s_read();
        chk("mid_rst_rdata", int'(s_rdata), 16'h1234);

        // FWFT: first word appears one edge after the write
        f_write(16'hA5A5);
        chk("fw_T_rempty", int'(f_rempty), 1);
        chk("fw_T_count",  int'(f_count),  1);
        tick();
        chk("fw_T1_rempty", int'(f_rempty), 0);
        chk("fw_T1_rdata",  int'(f_rdata),  16'hA5A5);
        f_rinc = 1'b1; tick(); f_rinc = 1'b0;
        chk("fw_pop_rempty", int'(f_rempty), 1);
        chk("fw_pop_count",  int'(f_count),  0);

        // FWFT: next word shows on the popping edge
        f_write(16'h00B1); f_write(16'h00B2); f_write(16'h00B3);
        tick();
        chk("fw_b1_rdata", int'(f_rdata), 16'h00B1);
        chk("fw_b1_count", int'(f_count), 3);
        f_rinc = 1'b1; tick();
        chk("fw_b2_rdata",  int'(f_rdata),  16'h00B2);
        chk("fw_b2_rempty", int'(f_rempty), 0);
        tick();
        chk("fw_b3_rdata",  int'(f_rdata),  16'h00B3);
        chk("fw_b3_count",  int'(f_count),  1);
        tick();
        f_rinc = 1'b0;
        chk("fw_end_rempty", int'(f_rempty), 1);
        chk("fw_end_count",  int'(f_count),  0);
        chk("fw_no_unf",     int'(f_unf),    0);
        f_rinc = 1'b1; tick(); f_rinc = 1'b0;
        chk("fw_unf", int'(f_unf), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
